// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and default sizing for the round-robin arbiter.
package arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_GAP} state_t;
    localparam int N_DEF = 4;
    localparam int MAX_HOLD_DEF = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit from ptr upward modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         valid
);
    logic [N-1:0] rot;
    assign rot = N'({req, req} >> ptr);
    always_comb begin
        idx = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = W'((int'(ptr) + i) % N);
                valid = 1'b1;
            end
        end
    end
    assign onehot = valid ? (N'(1) << idx) : '0;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with bounded hold time and a one-cycle turnaround gap.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy
);
    localparam int W = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    state_t state, state_d;
    logic [N-1:0] gnt_d, onehot;
    logic [W-1:0] id_d, ptr, ptr_d, idx;
    logic [HW-1:0] hold_cnt, hold_d;
    logic busy_d, valid, release_now;
    rr_pick #(.N(N), .W(W)) u_pick (
        .req(req),
        .ptr(ptr),
        .onehot(onehot),
        .idx(idx),
        .valid(valid)
    );
    assign release_now = !req[gnt_id] || hold_cnt == HW'(MAX_HOLD);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
            gnt <= '0;
            gnt_id <= '0;
            busy <= 1'b0;
            ptr <= '0;
            hold_cnt <= '0;
        end else begin
            state <= state_d;
            gnt <= gnt_d;
            gnt_id <= id_d;
            busy <= busy_d;
            ptr <= ptr_d;
            hold_cnt <= hold_d;
        end
    end
    // Releasing owner moves to lowest priority by advancing ptr past it.
    always_comb begin
        state_d = state;
        gnt_d = gnt;
        id_d = gnt_id;
        busy_d = busy;
        ptr_d = ptr;
        hold_d = hold_cnt;
        if (state == ARB_GRANT) begin
            if (release_now) begin
                state_d = ARB_GAP;
                gnt_d = '0;
                busy_d = 1'b0;
                ptr_d = (gnt_id == W'(N - 1)) ? '0 : gnt_id + 1'b1;
                hold_d = '0;
            end else begin
                hold_d = hold_cnt + 1'b1;
            end
        end else if (valid) begin
            state_d = ARB_GRANT;
            gnt_d = onehot;
            id_d = idx;
            busy_d = 1'b1;
            hold_d = HW'(1);
        end else begin
            state_d = ARB_IDLE;
            gnt_d = '0;
            busy_d = 1'b0;
        end
    end
endmodule
